// File: rtl/fm_demod_dec_if.sv
// Sample/result bus of the FM demodulator/decimator.
// The master side (source of samples) drives the input fields and observes
// the decimated baseband and demodulated results; the slave side is the core.
interface fm_demod_dec_if #(
  parameter int IN_W  = 8,
  parameter int PH_W  = 32,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  fm_in;
  logic        [PH_W-1:0]  phi_inc;
  logic        [1:0]       mode;
  logic signed [OUT_W-1:0] demod_out;
  logic                    out_valid;
  logic signed [OUT_W-1:0] I_dec;
  logic signed [OUT_W-1:0] Q_dec;
  logic                    sat;

  modport master (
    output in_valid, fm_in, phi_inc, mode,
    input  demod_out, out_valid, I_dec, Q_dec, sat
  );

  modport slave (
    input  in_valid, fm_in, phi_inc, mode,
    output demod_out, out_valid, I_dec, Q_dec, sat
  );
endinterface

// File: rtl/fm_demod_dec.sv
// FM demodulator with NCO down-mix, boxcar decimation and a cross-product
// discriminator. Pipeline: stage 1 (LUT lookup) -> stage 2 (mix) ->
// stage 3 (accumulate/decimate) -> stage 3b (discriminator products) ->
// stage 4 (mode select, saturate, output strobe).
// Saturation helper works on 64-bit values, so OUT_W is limited to 31 bits.
module fm_demod_dec #(
  parameter int IN_W   = 8,
  parameter int PH_W   = 32,
  parameter int LUT_AW = 10,
  parameter int TRIG_W = 8,
  parameter int DEC    = 8,
  parameter int SHIFT  = 8,
  parameter int OUT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  fm_demod_dec_if.slave bus
);

  localparam int LUT_N  = 32'd1 << LUT_AW;
  localparam int DEC_LG = $clog2(DEC);
  localparam int MIX_W  = IN_W + TRIG_W;
  localparam int ACC_W  = MIX_W + DEC_LG;
  localparam int PROD_W = 2 * OUT_W;
  localparam int DIFF_W = PROD_W + 1;
  localparam logic [DEC_LG-1:0] CNT_MAX = DEC_LG'(DEC - 1);

  // Rounded sin/cos table entry; only ever evaluated with constant arguments.
  function automatic logic signed [TRIG_W-1:0] trig_val(input int idx, input logic is_sin);
    real ang;
    real amp;
    real v;
    int  r;
    ang = 2.0 * 3.141592653589793 * $itor(idx) / $itor(LUT_N);
    amp = $itor((32'sd1 <<< (TRIG_W - 1)) - 32'sd1);
    if (is_sin) v = amp * $sin(ang);
    else        v = amp * $cos(ang);
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(0.5 - v);
    return TRIG_W'(r);
  endfunction

  // Clamp to the signed OUT_W range; MSB of the result flags a clamp.
  function automatic logic [OUT_W:0] sat_fn(input logic signed [63:0] v);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (OUT_W - 1));
    if (v > hi)      return {1'b1, hi[OUT_W-1:0]};
    else if (v < lo) return {1'b1, lo[OUT_W-1:0]};
    else             return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic signed [TRIG_W-1:0] cos_rom [LUT_N];
  logic signed [TRIG_W-1:0] sin_rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign cos_rom[k] = trig_val(k, 1'b0);
    assign sin_rom[k] = trig_val(k, 1'b1);
  end

  // NCO and stage 1
  logic [PH_W-1:0]          phase_q, phase_d;
  logic                     s1_vld_q, s1_vld_d;
  logic signed [IN_W-1:0]   s1_fm_q, s1_fm_d;
  logic signed [TRIG_W-1:0] s1_cos_q, s1_cos_d;
  logic signed [TRIG_W-1:0] s1_sin_q, s1_sin_d;
  // stage 2
  logic                     s2_vld_q, s2_vld_d;
  logic signed [MIX_W-1:0]  s2_i_q, s2_i_d;
  logic signed [MIX_W-1:0]  s2_q_q, s2_q_d;
  // stage 3
  logic [DEC_LG-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0]  acc_q_q, acc_q_d;
  logic                     dec_vld_q, dec_vld_d;
  logic signed [OUT_W-1:0]  i_dec_q, i_dec_d;
  logic signed [OUT_W-1:0]  q_dec_q, q_dec_d;
  // stage 3b
  logic                     prev_vld_q, prev_vld_d;
  logic signed [OUT_W-1:0]  i_prev_q, i_prev_d;
  logic signed [OUT_W-1:0]  q_prev_q, q_prev_d;
  logic                     p_vld_q, p_vld_d;
  logic signed [PROD_W-1:0] p_a_q, p_a_d;
  logic signed [PROD_W-1:0] p_b_q, p_b_d;
  // stage 4
  logic                     out_vld_q, out_vld_d;
  logic signed [OUT_W-1:0]  demod_q, demod_d;
  logic                     sat_q, sat_d;
  // combinational helpers
  logic [LUT_AW-1:0]        addr_s;
  logic signed [ACC_W-1:0]  sum_i_s, sum_q_s;
  logic [OUT_W:0]           dsat_i_s, dsat_q_s, dsat_m_s;
  logic signed [DIFF_W-1:0] diff_s;

  // Next-state logic for the NCO and every pipeline stage.
  always_comb begin
    phase_d    = phase_q;
    s1_vld_d   = bus.in_valid;
    s1_fm_d    = s1_fm_q;
    s1_cos_d   = s1_cos_q;
    s1_sin_d   = s1_sin_q;
    s2_vld_d   = s1_vld_q;
    s2_i_d     = s2_i_q;
    s2_q_d     = s2_q_q;
    cnt_d      = cnt_q;
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    dec_vld_d  = 1'b0;
    i_dec_d    = i_dec_q;
    q_dec_d    = q_dec_q;
    prev_vld_d = prev_vld_q;
    i_prev_d   = i_prev_q;
    q_prev_d   = q_prev_q;
    p_vld_d    = 1'b0;
    p_a_d      = p_a_q;
    p_b_d      = p_b_q;
    out_vld_d  = 1'b0;
    demod_d    = demod_q;
    sat_d      = sat_q;

    addr_s   = phase_q[PH_W-1 -: LUT_AW];
    sum_i_s  = acc_i_q + ACC_W'(s2_i_q);
    sum_q_s  = acc_q_q + ACC_W'(s2_q_q);
    dsat_i_s = sat_fn(64'(sum_i_s >>> DEC_LG));
    dsat_q_s = sat_fn(64'(sum_q_s >>> DEC_LG));
    diff_s   = DIFF_W'(p_a_q) - DIFF_W'(p_b_q);
    dsat_m_s = sat_fn(64'(diff_s >>> SHIFT));

    // The sample uses the pre-update phase; a new phi_inc only shapes the next step.
    if (bus.in_valid) begin
      phase_d  = phase_q + bus.phi_inc;
      s1_fm_d  = bus.fm_in;
      s1_cos_d = cos_rom[addr_s];
      s1_sin_d = sin_rom[addr_s];
    end else begin
      phase_d  = phase_q;
    end

    if (s1_vld_q) begin
      s2_i_d = MIX_W'(s1_fm_q) * MIX_W'(s1_cos_q);
      s2_q_d = -(MIX_W'(s1_fm_q) * MIX_W'(s1_sin_q));
    end else begin
      s2_i_d = s2_i_q;
      s2_q_d = s2_q_q;
    end

    // The DEC-th sample is folded into the dumped sum, so the restart loses nothing.
    if (s2_vld_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d     = '0;
        acc_i_d   = '0;
        acc_q_d   = '0;
        dec_vld_d = 1'b1;
        i_dec_d   = dsat_i_s[OUT_W-1:0];
        q_dec_d   = dsat_q_s[OUT_W-1:0];
        sat_d     = sat_d | dsat_i_s[OUT_W] | dsat_q_s[OUT_W];
      end else begin
        cnt_d   = cnt_q + DEC_LG'(1);
        acc_i_d = sum_i_s;
        acc_q_d = sum_q_s;
      end
    end else begin
      cnt_d = cnt_q;
    end

    // The first decimated pair after reset only primes the previous-pair registers.
    if (dec_vld_q) begin
      if (prev_vld_q) begin
        p_vld_d = 1'b1;
        p_a_d   = PROD_W'(i_prev_q) * PROD_W'(q_dec_q);
        p_b_d   = PROD_W'(q_prev_q) * PROD_W'(i_dec_q);
      end else begin
        p_vld_d = 1'b0;
      end
      prev_vld_d = 1'b1;
      i_prev_d   = i_dec_q;
      q_prev_d   = q_dec_q;
    end else begin
      prev_vld_d = prev_vld_q;
    end

    if (p_vld_q) begin
      out_vld_d = 1'b1;
      case (bus.mode)
        2'd0: begin
          demod_d = dsat_m_s[OUT_W-1:0];
          sat_d   = sat_d | dsat_m_s[OUT_W];
        end
        2'd1:    demod_d = i_dec_q;
        2'd2:    demod_d = q_dec_q;
        2'd3:    demod_d = '0;
        default: demod_d = '0;
      endcase
    end else begin
      out_vld_d = 1'b0;
    end
  end

  // State registers; reset clears every stage so a partial group is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      s1_vld_q   <= 1'b0;
      s1_fm_q    <= '0;
      s1_cos_q   <= '0;
      s1_sin_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_i_q     <= '0;
      s2_q_q     <= '0;
      cnt_q      <= '0;
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      dec_vld_q  <= 1'b0;
      i_dec_q    <= '0;
      q_dec_q    <= '0;
      prev_vld_q <= 1'b0;
      i_prev_q   <= '0;
      q_prev_q   <= '0;
      p_vld_q    <= 1'b0;
      p_a_q      <= '0;
      p_b_q      <= '0;
      out_vld_q  <= 1'b0;
      demod_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_vld_q   <= s1_vld_d;
      s1_fm_q    <= s1_fm_d;
      s1_cos_q   <= s1_cos_d;
      s1_sin_q   <= s1_sin_d;
      s2_vld_q   <= s2_vld_d;
      s2_i_q     <= s2_i_d;
      s2_q_q     <= s2_q_d;
      cnt_q      <= cnt_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      dec_vld_q  <= dec_vld_d;
      i_dec_q    <= i_dec_d;
      q_dec_q    <= q_dec_d;
      prev_vld_q <= prev_vld_d;
      i_prev_q   <= i_prev_d;
      q_prev_q   <= q_prev_d;
      p_vld_q    <= p_vld_d;
      p_a_q      <= p_a_d;
      p_b_q      <= p_b_d;
      out_vld_q  <= out_vld_d;
      demod_q    <= demod_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.demod_out = demod_q;
  assign bus.out_valid = out_vld_q;
  assign bus.I_dec     = i_dec_q;
  assign bus.Q_dec     = q_dec_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_fm_demod_dec.sv
// Directed bench for fm_demod_dec (default parameters).
// Inputs change on the falling edge; strobes are captured on the falling edge.
module tb_fm_demod_dec;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ov_cnt   = 0;
  int   last_cyc = 0;
  int   c16      = 0;
  int   base     = 0;
  longint got_cyc, got_dem, got_i, got_q, got_sat;
  longint c0, d0, i0, q0, s0;
  longint ov_cyc [$];
  longint ov_dem [$];
  longint ov_i   [$];
  longint ov_q   [$];
  longint ov_sat [$];

  fm_demod_dec_if bus ();

  fm_demod_dec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to measure strobe latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output strobe.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc.push_back(longint'(cyc));
      ov_dem.push_back(longint'(bus.demod_out));
      ov_i.push_back(longint'(bus.I_dec));
      ov_q.push_back(longint'(bus.Q_dec));
      ov_sat.push_back(longint'(bus.sat));
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic signed [7:0] fm, input logic [31:0] inc);
    @(negedge clk);
    bus.in_valid = v;
    bus.fm_in    = fm;
    bus.phi_inc  = inc;
    if (v) last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'sd0, 32'd0);
  endtask

  // Eight samples; only the last one carries last_inc (applies after it).
  task automatic feed_group(input logic signed [7:0] fm, input logic [31:0] last_inc, input logic gap);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, fm, (k == 7) ? last_inc : 32'd0);
      if (gap) drive(1'b0, fm, 32'd0);
    end
  endtask

  task automatic flush();
    ov_cyc.delete(); ov_dem.delete(); ov_i.delete(); ov_q.delete(); ov_sat.delete();
  endtask

  task automatic take();
    if (ov_dem.size() > 0) begin
      got_cyc = ov_cyc.pop_front();
      got_dem = ov_dem.pop_front();
      got_i   = ov_i.pop_front();
      got_q   = ov_q.pop_front();
      got_sat = ov_sat.pop_front();
    end else begin
      got_cyc = -64'sd99999; got_dem = -64'sd99999; got_i = -64'sd99999;
      got_q = -64'sd99999; got_sat = -64'sd99999;
    end
  endtask

  task automatic expect_one(input string tag, input longint dem, input longint i, input longint q, input longint s);
    chk({tag, "_count"}, longint'(ov_dem.size()), 64'sd1);
    take();
    chk({tag, "_demod"}, got_dem, dem);
    chk({tag, "_idec"},  got_i,   i);
    chk({tag, "_qdec"},  got_q,   q);
    chk({tag, "_sat"},   got_sat, s);
    flush();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_demod"}, longint'(bus.demod_out), 64'sd0);
    chk({tag, "_ovalid"}, longint'(bus.out_valid), 64'sd0);
    chk({tag, "_idec"}, longint'(bus.I_dec), 64'sd0);
    chk({tag, "_qdec"}, longint'(bus.Q_dec), 64'sd0);
    chk({tag, "_sat"}, longint'(bus.sat), 64'sd0);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    flush();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.fm_in    = 8'sd0;
    bus.phi_inc  = 32'd0;
    bus.mode     = 2'd0;

    // Reset values while rst is held, then 100 idle cycles without a strobe.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    base = ov_cnt;
    idle(100);
    chk("idle_no_strobe", longint'(ov_cnt - base), 64'sd0);
    flush();

    // Constant +100 at phase 0: I = 100*127 per sample, Q = 0.
    bus.mode = 2'd1;
    base = ov_cnt;
    feed_group(8'sd100, 32'd0, 1'b0);
    feed_group(8'sd100, 32'd0, 1'b0);
    c16 = last_cyc;
    idle(8);
    expect_one("m1", 64'sd12700, 64'sd12700, 64'sd0, 64'sd0);
    chk("m1_latency", got_cyc - longint'(c16), 64'sd5);
    bus.mode = 2'd0;
    feed_group(8'sd100, 32'd0, 1'b0);
    idle(8);
    expect_one("m0", 64'sd0, 64'sd12700, 64'sd0, 64'sd0);
    chk("strobe_width", longint'(ov_cnt - base), 64'sd2);

    // Same stream with in_valid on every other cycle.
    hard_reset();
    bus.mode = 2'd1;
    feed_group(8'sd100, 32'd0, 1'b1);
    feed_group(8'sd100, 32'd0, 1'b1);
    c16 = last_cyc;
    feed_group(8'sd100, 32'd0, 1'b1);
    idle(8);
    chk("gap_count", longint'(ov_dem.size()), 64'sd2);
    take();
    c0 = got_cyc; d0 = got_dem;
    take();
    chk("gap_latency", c0 - longint'(c16), 64'sd5);
    chk("gap_spacing", got_cyc - c0, 64'sd16);
    chk("gap_demod0", d0, 64'sd12700);
    chk("gap_demod1", got_dem, 64'sd12700);
    flush();

    // Discriminator: fm=4, phase stepped between 0 and a quarter turn.
    hard_reset();
    bus.mode = 2'd0;
    feed_group(8'sd4, 32'h4000_0000, 1'b0);
    idle(8);
    chk("first_pair_silent", longint'(ov_dem.size()), 64'sd0);
    flush();
    // (508,0) -> (0,-508): -258064 >>> 8 = -1009
    feed_group(8'sd4, 32'hC000_0000, 1'b0);
    idle(8);
    expect_one("disc_neg", -64'sd1009, 64'sd0, -64'sd508, 64'sd0);
    // (0,-508) -> (508,0): 258064 >>> 8 = 1008
    feed_group(8'sd4, 32'h4000_0000, 1'b0);
    idle(8);
    expect_one("disc_pos", 64'sd1008, 64'sd508, 64'sd0, 64'sd0);
    bus.mode = 2'd2;
    feed_group(8'sd4, 32'd0, 1'b0);
    idle(8);
    expect_one("mode2", -64'sd508, 64'sd0, -64'sd508, 64'sd0);
    bus.mode = 2'd3;
    feed_group(8'sd4, 32'd0, 1'b0);
    idle(8);
    expect_one("mode3", 64'sd0, 64'sd0, -64'sd508, 64'sd0);

    // Saturation with fm=100 and quarter-turn phase steps; sat stays sticky.
    hard_reset();
    bus.mode = 2'd0;
    feed_group(8'sd100, 32'h4000_0000, 1'b0);
    feed_group(8'sd100, 32'hC000_0000, 1'b0);
    idle(8);
    expect_one("sat_neg", -64'sd32768, 64'sd0, -64'sd12700, 64'sd1);
    feed_group(8'sd100, 32'd0, 1'b0);
    idle(8);
    expect_one("sat_pos", 64'sd32767, 64'sd12700, 64'sd0, 64'sd1);
    feed_group(8'sd100, 32'd0, 1'b0);
    idle(8);
    expect_one("sat_sticky", 64'sd0, 64'sd12700, 64'sd0, 64'sd1);

    // Reset five samples into a group, then a fresh stream of 16 samples.
    bus.mode = 2'd1;
    for (int k = 0; k < 5; k++) drive(1'b1, 8'sd100, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    flush();
    base = ov_cnt;
    feed_group(8'sd100, 32'd0, 1'b0);
    feed_group(8'sd100, 32'd0, 1'b0);
    c16 = last_cyc;
    idle(8);
    expect_one("post_rst", 64'sd12700, 64'sd12700, 64'sd0, 64'sd0);
    chk("post_rst_latency", got_cyc - longint'(c16), 64'sd5);
    chk("post_rst_strobes", longint'(ov_cnt - base), 64'sd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm_demod_dec.md
FM_DEMOD_DEC -- requirements
Module: fm_demod_dec

Interface
REQ-001 SHALL take parameter IN_W, default 8: signed input sample width.
REQ-002 SHALL take parameter PH_W, default 32: NCO phase accumulator width.
REQ-003 SHALL take parameter LUT_AW, default 10: sin/cos table address bits (top bits of the phase).
REQ-004 SHALL take parameter TRIG_W, default 8: signed sin/cos width, peak amplitude 2^(TRIG_W-1)-1.
REQ-005 SHALL take parameter DEC, default 8: decimation factor, power of 2, 2..256.
REQ-006 SHALL take parameter SHIFT, default 8: arithmetic right shift applied to the discriminator product.
REQ-007 SHALL take parameter OUT_W, default 16: signed output width.
REQ-008 SHALL have port clk  in  1  sole clock, rising edge.
REQ-009 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-010 SHALL have port in_valid  in  1  fm_in is valid this cycle.
REQ-011 SHALL have port fm_in  in  IN_W  signed FM sample.
REQ-012 SHALL have port phi_inc  in  PH_W  NCO increment per accepted sample.
REQ-013 SHALL have port mode  in  2  output select.
REQ-014 SHALL have port demod_out  out  OUT_W  signed result.
REQ-015 SHALL have port out_valid  out  1  single-cycle demod_out strobe.
REQ-016 SHALL have port I_dec, Q_dec  out  OUT_W each  decimated baseband, saturated.
REQ-017 SHALL have port sat  out  1  sticky saturation flag.

Function
REQ-018 NCO SHALL advance phase_acc by phi_inc (mod 2^PH_W) only on in_valid; the sample SHALL use the pre-update phase.
REQ-019 Stage 1 (edge sampling in_valid) SHALL register fm_in, cos and sin looked up from phase_acc[PH_W-1 -: LUT_AW].
REQ-020 Stage 2 SHALL register I_mix = fm_in*cos and Q_mix = -(fm_in*sin), full precision IN_W+TRIG_W bits.
REQ-021 Stage 3 SHALL accumulate DEC mixed samples per channel; a counter SHALL advance only on valid stage-2 data and wrap DEC-1 -> 0.
REQ-022 On the DEC-th sample, the sum >>> log2(DEC) SHALL be saturated to OUT_W into I_dec/Q_dec, and the accumulator SHALL restart with no sample lost.
REQ-023 Stage 4 mode 0 SHALL output (I_prev*Q_dec - Q_prev*I_dec) >>> SHIFT, saturated to OUT_W, using the previous decimated pair.
REQ-024 Mode 1 SHALL output I_dec, mode 2 SHALL output Q_dec, and mode 3 SHALL output 0.
REQ-025 mode SHALL be sampled at stage 4; a change SHALL affect the next strobe only.
REQ-026 out_valid SHALL pulse on the 4th rising edge after the edge sampling the DEC-th in_valid of a group; in_valid gaps SHALL only stretch, never drop, samples.
REQ-027 First decimated pair after reset SHALL only load I_prev/Q_prev and SHALL produce no out_valid in any mode.
REQ-028 Any clamp at REQ-022 or REQ-023 SHALL set sat, which SHALL clear only on rst.
REQ-029 phi_inc changes SHALL take effect on the next accepted sample, with no phase discontinuity.

Reset
REQ-030 rst SHALL clear phase_acc, all pipeline registers, the decimation counter, accumulators, I_prev/Q_prev, prev-valid, demod_out, I_dec, Q_dec, out_valid and sat to 0.
REQ-031 rst mid-group SHALL discard the partial group; the first out_valid after release SHALL need 2*DEC new samples.

Verification
REQ-032 Reset with rst=1 -> all outputs 0; after release with in_valid=0 held 100 cycles -> out_valid never asserts.
REQ-033 Defaults, phi_inc=0, fm_in=+100 continuous, mode 1 -> first out_valid after sample 16 + 4 edges, demod_out=12700, Q_dec=0; mode 0 -> demod_out=0.
REQ-034 Same as REQ-033 with in_valid toggling every other cycle -> identical values, out_valid spacing 16 cycles.
REQ-035 phi_inc=42949673 (1 MHz at 100 MHz), input cos at 1.05 MHz amplitude 127, mode 0 -> mean of 64 outputs in 5000..8000; at 0.95 MHz -> mean in -8000..-5000.
REQ-036 SHIFT=0, fm_in=+127 with large carrier offset -> demod_out clamps at +32767 or -32768 and sat=1 until rst.
REQ-037 rst pulsed after 5 samples of a group -> all state 0; next out_valid after exactly 16 post-release samples.
